// File: rtl/noc_router_output_port.sv
// Output port: round-robin arbitration of NUM_IN requesters into a DEPTH-entry FWFT FIFO feeding one link.
// Latency: a packet granted at edge N is on out_packet after edge N (no empty bypass).
// Backpressure: out_ready low holds the head; a full FIFO withholds every grant, even while popping.
module noc_router_output_port #(
    parameter int PKT_W  = 13,
    parameter int NUM_IN = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         req_valid,
    input  logic [NUM_IN*PKT_W-1:0]   req_packet,
    output logic [NUM_IN-1:0]         req_ready,
    output logic                      out_valid,
    output logic [PKT_W-1:0]          out_packet,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(NUM_IN);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] rr_ptr;

    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] next_rr;
    logic             grant;
    logic             pop;
    int               idx;

    // Rotating priority search starting at rr_ptr; first requester found wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    assign grant     = reset && found && (count != FULL_CNT);
    assign req_ready = grant ? (NUM_IN'(1) << winner) : '0;
    assign next_rr   = (winner == IDX_W'(NUM_IN - 1)) ? '0 : winner + 1'b1;

    assign out_valid  = (count != '0);
    assign out_packet = out_valid ? mem[rd_ptr] : '0;
    assign pop        = out_valid && out_ready;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (grant) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= next_rr;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({grant, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: out_packet is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (grant) mem[wr_ptr] <= req_packet[winner*PKT_W +: PKT_W];
    end

endmodule

// File: tb/tb_noc_router_output_port.sv
// Randomized bench for noc_router_output_port against a queue-based reference model.
module tb_noc_router_output_port;

    localparam int PKT_W  = 13;
    localparam int NUM_IN = 4;
    localparam int DEPTH  = 4;

    logic                    clk;
    logic                    reset;
    logic [NUM_IN-1:0]       req_valid;
    logic [NUM_IN*PKT_W-1:0] req_packet;
    logic [NUM_IN-1:0]       req_ready;
    logic                    out_valid;
    logic [PKT_W-1:0]        out_packet;
    logic                    out_ready;
    logic [2:0]              fifo_count;

    logic [PKT_W-1:0] pkt [NUM_IN];

    int errors = 0;
    int checks = 0;

    // Reference model: packet queue plus next-priority index.
    logic [PKT_W-1:0] mq[$];
    int               mrr = 0;

    noc_router_output_port #(.PKT_W(PKT_W), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_packet (req_packet),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_packet (out_packet),
        .out_ready  (out_ready),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_packet = '0;
        for (int i = 0; i < NUM_IN; i++) req_packet[i*PKT_W +: PKT_W] = pkt[i];
    end

    function automatic int model_winner();
        int j;
        if (!reset || mq.size() >= DEPTH) return -1;
        for (int k = 0; k < NUM_IN; k++) begin
            j = (mrr + k) % NUM_IN;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NUM_IN-1:0] exp_ready();
        int w;
        w = model_winner();
        if (w < 0) return '0;
        return NUM_IN'(1) << w;
    endfunction

    function automatic logic [PKT_W-1:0] exp_packet();
        if (mq.size() == 0) return '0;
        return mq[0];
    endfunction

    // Advance one clock edge, update the model from the inputs seen at that edge, then settle.
    task automatic tick();
        int w;
        bit pop;
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            mrr = 0;
        end else begin
            w   = model_winner();
            pop = (mq.size() != 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (w >= 0) begin
                mq.push_back(pkt[w]);
                mrr = (w + 1) % NUM_IN;
            end
        end
        #1;
    endtask

    task automatic randomize_pkts();
        for (int i = 0; i < NUM_IN; i++) pkt[i] = PKT_W'($urandom);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        randomize_pkts();
        tick();
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count);
        end
        checks++;
        if (out_packet !== '0) begin
            errors++; $display("FAIL reset_out_packet got=%h exp=0", out_packet);
        end
    endtask

    task automatic test_single_path();
        reset     = 1'b1;
        req_valid = 4'b0010;
        pkt[1]    = 13'h1A5;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL single_grant got=%b exp=0010", req_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_no_bypass got=%b exp=0", out_valid);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_packet !== 13'h1A5) begin
            errors++; $display("FAIL single_out got=%b/%h exp=1/1a5", out_valid, out_packet);
        end
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++; $display("FAIL single_count1 got=%0d exp=1", fifo_count);
        end
        tick();
        checks++;
        if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain got=%0d/%b exp=0/0", fifo_count, out_valid);
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            randomize_pkts();
            #1;
            checks++;
            if (req_ready !== (NUM_IN'(1) << (c % NUM_IN))) begin
                errors++; $display("FAIL rr_order cycle=%0d got=%b exp_idx=%0d", c, req_ready, c % NUM_IN);
            end
            checks++;
            if (out_packet !== exp_packet() || out_valid !== (mq.size() != 0)) begin
                errors++; $display("FAIL rr_out cycle=%0d got=%h exp=%h", c, out_packet, exp_packet());
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_full_backpressure();
        out_ready = 1'b0;
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            randomize_pkts();
            #1;
            checks++;
            if (req_ready !== ((c < DEPTH) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL full_grant cycle=%0d got=%b", c, req_ready);
            end
            tick();
        end
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++; $display("FAIL full_count got=%0d exp=4", fifo_count);
        end
        out_ready = 1'b1;
        randomize_pkts();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL full_no_bypass got=%b exp=0000", req_ready);
        end
        tick();
        checks++;
        if (fifo_count !== 3'd3 || req_ready !== 4'b0001) begin
            errors++; $display("FAIL full_after_pop got=%0d/%b exp=3/0001", fifo_count, req_ready);
        end
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (out_packet !== exp_packet() || fifo_count !== 3'(mq.size())) begin
                errors++; $display("FAIL full_drain step=%0d got=%h/%0d exp=%h/%0d",
                                   c, out_packet, fifo_count, exp_packet(), mq.size());
            end
            if (c == 0) req_valid = 4'b0001;
            else        req_valid = '0;
            tick();
        end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        req_valid = 4'b0100;
        randomize_pkts();
        tick();
        randomize_pkts();
        tick();
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            randomize_pkts();
            #1;
            checks++;
            if (fifo_count !== 3'd2) begin
                errors++; $display("FAIL pushpop_count cycle=%0d got=%0d exp=2", c, fifo_count);
            end
            checks++;
            if (out_packet !== exp_packet()) begin
                errors++; $display("FAIL pushpop_head cycle=%0d got=%h exp=%h", c, out_packet, exp_packet());
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            randomize_pkts();
            tick();
        end
        checks++;
        if (fifo_count !== 3'd3) begin
            errors++; $display("FAIL mid_fill got=%0d exp=3", fifo_count);
        end
        reset     = 1'b0;
        req_valid = 4'b1111;
        tick();
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/0000", out_valid, fifo_count, req_ready);
        end
        reset     = 1'b1;
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = '0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 39) != 0);
            req_valid = NUM_IN'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            randomize_pkts();
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", c, req_ready, exp_ready());
            end
            checks++;
            if (out_valid !== (mq.size() != 0) || out_packet !== exp_packet()) begin
                errors++; $display("FAIL rand_out cycle=%0d got=%b/%h exp=%b/%h",
                                   c, out_valid, out_packet, mq.size() != 0, exp_packet());
            end
            checks++;
            if (fifo_count !== 3'(mq.size())) begin
                errors++; $display("FAIL rand_count cycle=%0d got=%0d exp=%0d", c, fifo_count, mq.size());
            end
            tick();
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NUM_IN; i++) pkt[i] = '0;
        test_reset();
        test_single_path();
        test_round_robin();
        test_full_backpressure();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
